spr_line_sched: RTL and testbench

//  Per-scanline sprite scheduler feeding the NUM_UNITS sprite render units. On each line_start
//  (start of hblank) it scans OAM for sprites on next_line, fetches their pattern bytes and loads

---
 rtl/spr_line_sched.sv | 209 ++++++++++++++++++++
 tb/tb_spr_line_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spr_line_sched.sv
// Per-scanline sprite scheduler: scans OAM in hblank, fetches pattern bytes for up to
// NUM_UNITS hits, then loads each render unit and arms draw_en on line_go.
module spr_line_sched #(
  parameter int NUM_UNITS   = 8,
  parameter int OAM_ENTRIES = 64,
  parameter int SPR_H       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 line_start,
  input  logic                 line_go,
  input  logic [7:0]           next_line,
  input  logic                 pt_sel,
  output logic [7:0]           oam_addr,
  input  logic [7:0]           oam_data,
  output logic                 pat_req,
  output logic [12:0]          pat_addr,
  input  logic                 pat_ack,
  input  logic [7:0]           pat_data,
  output logic [31:0]          rend_buf,
  output logic [NUM_UNITS-1:0] rend_now,
  output logic [NUM_UNITS-1:0] draw_en,
  output logic                 overflow,
  output logic                 late_err,
  output logic                 busy
);

  localparam int EW = $clog2(OAM_ENTRIES);
  localparam int CW = $clog2(NUM_UNITS + 1);
  localparam int SW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EVAL  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_READY = 3'd4;

  logic [2:0]                      state_q, state_d;
  logic [7:0]                      line_q, line_d;
  logic [EW-1:0]                   ent_q, ent_d;
  logic [1:0]                      byte_q, byte_d;
  logic                            smp_q, smp_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [SW-1:0]                   idx_q, idx_d;
  logic                            plane_q, plane_d;
  logic                            ldph_q, ldph_d;
  logic                            late_q, late_d;
  logic [NUM_UNITS-1:0][7:0]       tile_q, tile_d, attr_q, attr_d, xpos_q, xpos_d;
  logic [NUM_UNITS-1:0][7:0]       p0_q, p0_d, p1_q, p1_d;
  logic [NUM_UNITS-1:0][2:0]       diff_q, diff_d;
  logic [7:0]                      oam_addr_q, oam_addr_d;
  logic                            pat_req_q, pat_req_d;
  logic [12:0]                     pat_addr_q, pat_addr_d;
  logic [31:0]                     rend_buf_q, rend_buf_d;
  logic [NUM_UNITS-1:0]            rend_now_q, rend_now_d, draw_en_q, draw_en_d, mask_w;
  logic                            overflow_q, overflow_d, late_err_q, late_err_d;

  logic [7:0]    diff_w;
  logic          hit_w, last_ent, last_idx, eval_next, eval_done;
  logic [2:0]    row_w;
  logic [SW-1:0] sidx;
  logic [31:0]   word_w;

  assign diff_w   = line_q - oam_data;
  assign hit_w    = diff_w < 8'(SPR_H);
  assign last_ent = ent_q == EW'(OAM_ENTRIES - 1);
  assign last_idx = (CW'(idx_q) + CW'(1)) == cnt_q;
  assign sidx     = cnt_q[SW-1:0];
  // Vertical flip mirrors the row within the 8-row sprite.
  assign row_w    = attr_q[idx_q][7] ? ~diff_q[idx_q] : diff_q[idx_q];
  assign word_w   = {1'b0, attr_q[idx_q][6], attr_q[idx_q][5], 3'b000, attr_q[idx_q][1:0],
                     xpos_q[idx_q], p1_q[idx_q], p0_q[idx_q]};

  always_comb begin
    mask_w = '0;
    for (int i = 0; i < NUM_UNITS; i++) mask_w[i] = (i < int'(cnt_q));
  end

  always_comb begin
    state_d = state_q;  line_d = line_q;  ent_d = ent_q;  byte_d = byte_q;  smp_d = smp_q;
    cnt_d = cnt_q;  idx_d = idx_q;  plane_d = plane_q;  ldph_d = ldph_q;  late_d = late_q;
    tile_d = tile_q;  attr_d = attr_q;  xpos_d = xpos_q;  diff_d = diff_q;
    p0_d = p0_q;  p1_d = p1_q;  oam_addr_d = oam_addr_q;  pat_req_d = pat_req_q;
    pat_addr_d = pat_addr_q;  rend_buf_d = rend_buf_q;  rend_now_d = '0;
    draw_en_d = draw_en_q;  overflow_d = overflow_q;  late_err_d = 1'b0;
    eval_next = 1'b0;  eval_done = 1'b0;

    case (state_q)
      S_EVAL: begin
        // Alternate address cycle and data cycle: OAM returns data one cycle late.
        if (!smp_q) begin
          smp_d = 1'b1;
        end else begin
          smp_d = 1'b0;
          case (byte_q)
            2'd0: begin
              if (hit_w && cnt_q == CW'(NUM_UNITS)) begin
                overflow_d = 1'b1;
                eval_done  = 1'b1;
              end else if (hit_w) begin
                diff_d[sidx] = diff_w[2:0];
                byte_d       = 2'd1;
              end else begin
                eval_next = 1'b1;
              end
            end
            2'd1: begin tile_d[sidx] = oam_data; byte_d = 2'd2; end
            2'd2: begin attr_d[sidx] = oam_data; byte_d = 2'd3; end
            default: begin
              xpos_d[sidx] = oam_data;
              cnt_d        = cnt_q + CW'(1);
              eval_next    = 1'b1;
            end
          endcase
          if (eval_next) begin
            if (last_ent) eval_done = 1'b1;
            else begin
              ent_d  = ent_q + EW'(1);
              byte_d = 2'd0;
            end
          end
          if (eval_done) begin
            state_d = (cnt_d != '0) ? S_FETCH : S_READY;
            idx_d   = '0;
            plane_d = 1'b0;
          end
        end
        oam_addr_d = 8'({ent_d, byte_d});
      end
      S_FETCH: begin
        if (!pat_req_q) begin
          pat_req_d  = 1'b1;
          pat_addr_d = {pt_sel, tile_q[idx_q], plane_q, row_w};
        end else if (pat_ack) begin
          pat_req_d = 1'b0;
          plane_d   = ~plane_q;
          if (!plane_q) p0_d[idx_q] = pat_data;
          else begin
            p1_d[idx_q] = pat_data;
            if (last_idx) begin
              state_d = S_LOAD;
              idx_d   = '0;
              ldph_d  = 1'b0;
            end else begin
              idx_d = idx_q + SW'(1);
            end
          end
        end
      end
      S_LOAD: begin
        if (!ldph_q) begin
          rend_buf_d = word_w;
          ldph_d     = 1'b1;
        end else begin
          rend_now_d = NUM_UNITS'(1) << idx_q;
          ldph_d     = 1'b0;
          if (last_idx) state_d = S_READY;
          else          idx_d   = idx_q + SW'(1);
        end
      end
      S_READY: begin
        if (line_go) begin
          draw_en_d = late_q ? '0 : mask_w;
          state_d   = S_IDLE;
        end
      end
      default: ;
    endcase

    if (line_go && (state_q == S_EVAL || state_q == S_FETCH || state_q == S_LOAD)) begin
      late_err_d = 1'b1;
      late_d     = 1'b1;
    end

    if (line_start) begin
      state_d = S_EVAL;  line_d = next_line;  ent_d = '0;  byte_d = 2'd0;  smp_d = 1'b0;
      cnt_d = '0;  oam_addr_d = 8'd0;  pat_req_d = 1'b0;  rend_now_d = '0;
      draw_en_d = '0;  overflow_d = 1'b0;  late_d = 1'b0;  late_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  line_q <= '0;  ent_q <= '0;  byte_q <= '0;  smp_q <= 1'b0;
      cnt_q <= '0;  idx_q <= '0;  plane_q <= 1'b0;  ldph_q <= 1'b0;  late_q <= 1'b0;
      tile_q <= '0;  attr_q <= '0;  xpos_q <= '0;  diff_q <= '0;  p0_q <= '0;  p1_q <= '0;
      oam_addr_q <= '0;  pat_req_q <= 1'b0;  pat_addr_q <= '0;  rend_buf_q <= '0;
      rend_now_q <= '0;  draw_en_q <= '0;  overflow_q <= 1'b0;  late_err_q <= 1'b0;
    end else begin
      state_q <= state_d;  line_q <= line_d;  ent_q <= ent_d;  byte_q <= byte_d;  smp_q <= smp_d;
      cnt_q <= cnt_d;  idx_q <= idx_d;  plane_q <= plane_d;  ldph_q <= ldph_d;  late_q <= late_d;
      tile_q <= tile_d;  attr_q <= attr_d;  xpos_q <= xpos_d;  diff_q <= diff_d;
      p0_q <= p0_d;  p1_q <= p1_d;  oam_addr_q <= oam_addr_d;  pat_req_q <= pat_req_d;
      pat_addr_q <= pat_addr_d;  rend_buf_q <= rend_buf_d;  rend_now_q <= rend_now_d;
      draw_en_q <= draw_en_d;  overflow_q <= overflow_d;  late_err_q <= late_err_d;
    end
  end

  assign oam_addr = oam_addr_q;
  assign pat_req  = pat_req_q;
  assign pat_addr = pat_addr_q;
  assign rend_buf = rend_buf_q;
  assign rend_now = rend_now_q;
  assign draw_en  = draw_en_q;
  assign overflow = overflow_q;
  assign late_err = late_err_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_READY);

endmodule

// File: tb/tb_spr_line_sched.sv
// Directed bench for spr_line_sched: OAM/pattern memory models plus queue scoreboards
// for pattern addresses and render-unit loads.
module tb_spr_line_sched;

  typedef struct packed {
    logic [7:0]  now;
    logic [31:0] word;
  } ld_t;

  logic        clk, rst_n, line_start, line_go, pt_sel, pat_req, pat_ack;
  logic        overflow, late_err, busy;
  logic [7:0]  next_line, oam_addr, oam_data, pat_data, rend_now, draw_en;
  logic [12:0] pat_addr;
  logic [31:0] rend_buf;

  spr_line_sched dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_go(line_go),
    .next_line(next_line), .pt_sel(pt_sel), .oam_addr(oam_addr), .oam_data(oam_data),
    .pat_req(pat_req), .pat_addr(pat_addr), .pat_ack(pat_ack), .pat_data(pat_data),
    .rend_buf(rend_buf), .rend_now(rend_now), .draw_en(draw_en), .overflow(overflow),
    .late_err(late_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int ack_dly = 0;
  int wait_cnt = 0;
  int req_rises = 0;
  logic [12:0] req_addr;
  logic [31:0] prev_buf;
  logic [7:0]  oam [256];
  logic [12:0] exp_addr_q [$];
  ld_t         exp_ld_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] patf(input logic [12:0] a);
    return a[7:0] ^ {a[12:8], 3'b101};
  endfunction

  always @(posedge clk) oam_data <= oam[oam_addr];

  // Pattern memory: acks after ack_dly extra cycles, checks address against scoreboard.
  always @(negedge clk) begin
    pat_ack = 1'b0;
    if (!pat_req) wait_cnt = 0;
    else begin
      if (wait_cnt == 0) begin
        req_addr = pat_addr;
        req_rises++;
      end
      if (wait_cnt >= ack_dly) begin
        pat_ack  = 1'b1;
        pat_data = patf(pat_addr);
        if (wait_cnt > 0) chk("pat_stable", 64'(pat_addr), 64'(req_addr));
        if (exp_addr_q.size() == 0) chk("pat_unexpected", 64'(pat_req), 64'd0);
        else chk("pat_addr", 64'(pat_addr), 64'(exp_addr_q.pop_front()));
      end
      wait_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && rend_now !== 8'h00) begin
      if (exp_ld_q.size() == 0) chk("rend_unexpected", 64'(rend_now), 64'd0);
      else begin
        ld_t e;
        e = exp_ld_q.pop_front();
        chk("rend_now", 64'(rend_now), 64'(e.now));
        chk("rend_buf", 64'(rend_buf), 64'(e.word));
        chk("rend_hold", 64'(rend_buf), 64'(prev_buf));
      end
    end
    prev_buf = rend_buf;
  end

  task automatic clear_oam();
    for (int i = 0; i < 256; i++) oam[i] = (i % 4 == 0) ? 8'hF0 : 8'h00;
  endtask

  task automatic set_ent(input int e, input logic [7:0] y, t, a, x);
    oam[4*e] = y;  oam[4*e+1] = t;  oam[4*e+2] = a;  oam[4*e+3] = x;
  endtask

  task automatic sched_model(input logic [7:0] line, input logic ps);
    logic [7:0] y, t, at, x, d;
    logic [2:0] row;
    logic [12:0] a0, a1;
    ld_t ld;
    int cnt;
    cnt = 0;
    for (int e = 0; e < 64; e++) begin
      y = oam[4*e];  t = oam[4*e+1];  at = oam[4*e+2];  x = oam[4*e+3];
      d = line - y;
      if (d < 8'd8) begin
        if (cnt == 8) break;
        row = at[7] ? 3'(8'd7 - d) : d[2:0];
        a0 = {ps, t, 1'b0, row};
        a1 = a0 | 13'h008;
        exp_addr_q.push_back(a0);
        exp_addr_q.push_back(a1);
        ld.now  = 8'(1 << cnt);
        ld.word = {1'b0, at[6], at[5], 3'b000, at[1:0], x, patf(a1), patf(a0)};
        exp_ld_q.push_back(ld);
        cnt++;
      end
    end
  endtask

  task automatic start_line(input logic [7:0] line);
    @(negedge clk);
    next_line = line;  line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic pulse_go();
    @(negedge clk);
    line_go = 1'b1;
    @(negedge clk);
    line_go = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 4000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk({tag, "_done"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (pat_req) break;
      @(negedge clk);
    end
    chk({tag, "_req"}, 64'(pat_req), 64'd1);
  endtask

  task automatic finish_line(input string tag, input logic exp_ovf, input logic [7:0] exp_draw);
    wait_idle(tag);
    @(negedge clk);
    chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    chk({tag, "_pat_left"}, 64'(exp_addr_q.size()), 64'd0);
    chk({tag, "_ld_left"}, 64'(exp_ld_q.size()), 64'd0);
    pulse_go();
    chk({tag, "_draw"}, 64'(draw_en), 64'(exp_draw));
    chk({tag, "_late"}, 64'(late_err), 64'd0);
  endtask

  initial begin
    int rises0;
    ld_t ld;
    rst_n = 1'b0;  line_start = 1'b0;  line_go = 1'b0;  next_line = 8'd0;
    pt_sel = 1'b0;  pat_ack = 1'b0;  pat_data = 8'd0;
    clear_oam();
    repeat (3) @(negedge clk);
    chk("rst_oam_addr", 64'(oam_addr), 64'd0);
    chk("rst_pat", 64'({pat_req, pat_addr}), 64'd0);
    chk("rst_rend", 64'({rend_now, rend_buf}), 64'd0);
    chk("rst_flags", 64'({draw_en, overflow, late_err, busy}), 64'd0);
    rst_n = 1'b1;
    pulse_go();
    chk("idle_go_late", 64'(late_err), 64'd0);
    chk("idle_go_draw", 64'(draw_en), 64'd0);

    // Reference sprite: row 3, pattern table 1.
    set_ent(0, 8'd10, 8'h21, 8'h41, 8'd50);
    pt_sel = 1'b1;  ack_dly = 0;
    exp_addr_q.push_back(13'h1213);
    exp_addr_q.push_back(13'h121B);
    ld = '{now: 8'h01, word: {16'h4132, patf(13'h121B), patf(13'h1213)}};
    exp_ld_q.push_back(ld);
    start_line(8'd13);
    chk("s1_busy", 64'(busy), 64'd1);
    finish_line("s1", 1'b0, 8'h01);

    // Vertical flip, pattern table 0, slow acks.
    set_ent(0, 8'd10, 8'h21, 8'h80, 8'd50);
    pt_sel = 1'b0;  ack_dly = 5;
    exp_addr_q.push_back(13'h0214);
    exp_addr_q.push_back(13'h021C);
    ld = '{now: 8'h01, word: {16'h0032, patf(13'h021C), patf(13'h0214)}};
    exp_ld_q.push_back(ld);
    start_line(8'd13);
    finish_line("s2", 1'b0, 8'h01);

    // line_go arriving during FETCH.
    ack_dly = 3;
    sched_model(8'd13, 1'b0);
    start_line(8'd13);
    wait_req("s3");
    pulse_go();
    chk("s3_late_pulse", 64'(late_err), 64'd1);
    @(negedge clk);
    chk("s3_late_end", 64'(late_err), 64'd0);
    finish_line("s3", 1'b0, 8'h00);

    // Ten hits: first eight loaded, overflow flagged.
    clear_oam();
    for (int i = 0; i < 10; i++)
      set_ent(i, 8'(100 - (i % 8)), 8'(8'h10 + i), 8'(i * 8'h29), 8'(20 + i * 13));
    pt_sel = 1'b1;  ack_dly = 1;
    sched_model(8'd100, 1'b1);
    start_line(8'd100);
    finish_line("s4", 1'b1, 8'hFF);

    // Y wrap-around: diff 8 misses, Y=0xFF hits on low lines.
    clear_oam();
    set_ent(0, 8'd250, 8'h05, 8'h22, 8'd7);
    set_ent(1, 8'hFF, 8'h06, 8'hC3, 8'd9);
    pt_sel = 1'b0;  ack_dly = 0;
    sched_model(8'd2, 1'b0);
    start_line(8'd2);
    finish_line("s5a", 1'b0, 8'h01);
    sched_model(8'd4, 1'b0);
    start_line(8'd4);
    finish_line("s5b", 1'b0, 8'h01);

    // Empty line.
    clear_oam();
    rises0 = req_rises;
    start_line(8'd50);
    finish_line("s6", 1'b0, 8'h00);
    chk("s6_no_req", 64'(req_rises), 64'(rises0));

    // Restart in the middle of FETCH.
    set_ent(0, 8'd10, 8'h21, 8'h41, 8'd50);
    pt_sel = 1'b1;  ack_dly = 8;
    sched_model(8'd13, 1'b1);
    start_line(8'd13);
    wait_req("s7");
    repeat (2) @(negedge clk);
    start_line(8'd13);
    chk("s7_req_drop", 64'(pat_req), 64'd0);
    chk("s7_oam_restart", 64'(oam_addr), 64'd0);
    chk("s7_busy", 64'(busy), 64'd1);
    finish_line("s7", 1'b0, 8'h01);

    // line_start and line_go together: the restart wins, no late flag.
    ack_dly = 0;
    sched_model(8'd13, 1'b1);
    start_line(8'd13);
    repeat (5) @(negedge clk);
    line_start = 1'b1;  line_go = 1'b1;
    @(negedge clk);
    line_start = 1'b0;  line_go = 1'b0;
    chk("s8_late", 64'(late_err), 64'd0);
    chk("s8_oam_restart", 64'(oam_addr), 64'd0);
    finish_line("s8", 1'b0, 8'h01);

    // Asynchronous reset during LOAD.
    clear_oam();
    for (int i = 0; i < 10; i++)
      set_ent(i, 8'(100 - (i % 8)), 8'(8'h30 + i), 8'(8'hFF - i), 8'(i * 7));
    sched_model(8'd100, 1'b1);
    start_line(8'd100);
    for (int i = 0; i < 4000; i++) begin
      if (rend_now !== 8'h00) break;
      @(negedge clk);
    end
    chk("s9_in_load", 64'(rend_now != 8'h00), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s9_oam_addr", 64'(oam_addr), 64'd0);
    chk("s9_pat", 64'({pat_req, pat_addr}), 64'd0);
    chk("s9_rend", 64'({rend_now, rend_buf}), 64'd0);
    chk("s9_flags", 64'({draw_en, overflow, late_err, busy}), 64'd0);
    exp_addr_q.delete();
    exp_ld_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s9_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
